// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution and a single-entry valid/ready output register.
// Branches always compare rs1 against rs2 with a subtract, whatever the ALU controls say.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_control,
    input  logic        in_alu_src,
    input  logic        in_branch,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_branch_taken,
    output logic [31:0] out_branch_target
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [3:0]      w_op;
    logic [XLEN-1:0] w_b;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_result;
    logic            w_carry;
    logic            w_ovf;
    logic            w_zero;
    logic            w_neg;
    logic            w_slt;
    logic            w_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_capture;

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [RW-1:0]   r_rd;
    logic            r_reg_write;
    logic            r_taken;
    logic [XLEN-1:0] r_target;

    // Operand selection and ALU; carry is bit 32 of the zero-extended add/sub
    always_comb begin
        w_op     = in_branch ? OP_SUB : in_alu_control;
        w_b      = (in_branch || !in_alu_src) ? in_rs2 : in_imm;
        w_sum    = {1'b0, in_rs1} + {1'b0, w_b};
        w_diff   = {1'b0, in_rs1} - {1'b0, w_b};
        w_slt    = ($signed(in_rs1) < $signed(w_b));
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_result = w_sum[XLEN-1:0];
                w_carry  = w_sum[XLEN];
                w_ovf    = (in_rs1[XLEN-1] == w_b[XLEN-1]) &&
                           (w_sum[XLEN-1] != in_rs1[XLEN-1]);
            end
            OP_SUB: begin
                w_result = w_diff[XLEN-1:0];
                w_carry  = w_diff[XLEN];
                w_ovf    = (in_rs1[XLEN-1] != w_b[XLEN-1]) &&
                           (w_diff[XLEN-1] != in_rs1[XLEN-1]);
            end
            OP_AND:  w_result = in_rs1 & w_b;
            OP_OR:   w_result = in_rs1 | w_b;
            OP_SLT:  w_result = XLEN'(w_slt);
            default: w_result = '0;
        endcase
        w_zero = (w_result == '0);
        w_neg  = w_result[XLEN-1];
    end

    // Branch condition from the forced-subtract flags
    always_comb begin
        w_cond = 1'b0;
        case (in_funct3)
            F3_BEQ:  w_cond = w_zero;
            F3_BNE:  w_cond = !w_zero;
            F3_BLT:  w_cond = w_neg ^ w_ovf;
            F3_BGE:  w_cond = !(w_neg ^ w_ovf);
            F3_BLTU: w_cond = w_carry;
            F3_BGEU: w_cond = !w_carry;
            default: w_cond = 1'b0;
        endcase
        w_taken  = in_branch && w_cond;
        w_target = in_pc + in_imm;
    end

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    // Output register: flush beats capture, capture beats drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_result    <= w_result;
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write && !in_branch;
            r_taken     <= w_taken;
            r_target    <= w_target;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid         = r_valid;
    assign out_result        = r_result;
    assign out_rd            = r_rd;
    assign out_reg_write     = r_reg_write;
    assign out_branch_taken  = r_taken;
    assign out_branch_target = r_target;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
No parameters; datapath width fixed at 32 bits.
REQ-001 SHALL have: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  upstream (decode) offers an operation.
REQ-004 SHALL have: in_ready  output  1  stage can accept this cycle.
REQ-005 SHALL have: in_pc, in_rs1, in_rs2, in_imm  input  32 each  PC, register operands, sign-extended immediate.
REQ-006 SHALL have: in_alu_control  input  4  ALU op; encodings ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0100, others yield result 0.
REQ-007 SHALL have: in_alu_src  input  1  operand-b select, 0 = in_rs2, 1 = in_imm.
REQ-008 SHALL have: in_branch  input  1  conditional branch; in_funct3  input  3  RV32I branch condition.
REQ-009 SHALL have: in_rd  input  5  destination register; in_reg_write  input  1  writeback enable.
REQ-010 SHALL have: flush  input  1  discard held and incoming operation.
REQ-011 SHALL have: out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-012 SHALL have: out_result  output  32; out_rd  output  5; out_reg_write  output  1.
REQ-013 SHALL have: out_branch_taken  output  1; out_branch_target  output  32.

Function
REQ-014 SHALL compute with the team ALU semantics: a = in_rs1; b per in_alu_src; flags zero, neg, carry (bit 32 of 33-bit zero-extended add/sub), overflow.
REQ-015 SHALL, when in_branch=1, force op = SUB and b = in_rs2 regardless of in_alu_control/in_alu_src.
REQ-016 SHALL decide taken from the SUB flags: 000 BEQ=zero; 001 BNE=~zero; 100 BLT=neg^overflow; 101 BGE=~(neg^overflow); 110 BLTU=carry; 111 BGEU=~carry; 010/011 = not taken.
REQ-017 SHALL compute branch target = in_pc + in_imm modulo 2^32 (wrap, no flag).
REQ-018 SHALL force registered out_reg_write=0 for branches; out_branch_taken=0 for non-branches; out_result holds the ALU output in both cases.
REQ-019 SHALL drive in_ready = ~out_valid | out_ready, combinationally, independent of in_valid.
REQ-020 SHALL capture all output fields on an edge where in_valid & in_ready & ~flush; out_valid=1 after that edge (latency 1 cycle).
REQ-021 SHALL clear out_valid on an edge where out_valid & out_ready and no new capture occurs.
REQ-022 SHALL support back-to-back transfers: simultaneous drain and capture on one edge keeps out_valid=1 with new data (full throughput).
REQ-023 SHALL hold all output fields stable while out_valid=1 & out_ready=0.
REQ-024 SHALL, on an edge with flush=1, clear out_valid and capture nothing, taking priority over every handshake; data fields may retain stale values.
REQ-025 SHALL leave output data fields unchanged when out_valid=0 and no capture occurs.

Reset
REQ-026 SHALL, while reset=1, immediately force out_valid, out_result, out_rd, out_reg_write, out_branch_taken, out_branch_target to 0, independent of clk.
REQ-027 SHALL, after reset deasserts, present in_ready=1 and accept on the first rising edge with in_valid=1.
REQ-028 SHALL discard any held operation when reset asserts mid-transfer; no output valid until a new capture.

Verification
REQ-029 ADD: rs1=0x7FFFFFFF, rs2=1, alu_src=0, rd=5, reg_write=1 -> next cycle out_valid=1, out_result=0x80000000, out_rd=5, out_reg_write=1, branch_taken=0.
REQ-030 BLTU vs BLT: rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=0xFFFFFFF0 -> funct3=110 taken=1, target=0x000000F0, reg_write=0; funct3=100 taken=0.
REQ-031 BEQ with in_alu_control=AND, alu_src=1: rs1=rs2=0x1234 -> taken=1, out_result=0 (SUB forced).
REQ-032 Backpressure: out_ready=0 two cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> drain and next capture on same edge, no op lost or duplicated.
REQ-033 Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0; following op accepted normally.
REQ-034 Async reset mid-stall: assert reset between clk edges with out_valid=1 -> out_valid and all outputs 0 before next edge; in_ready=1.
